quad_pixel_fetch: RTL and testbench

Responder side of the bilinear quad-pixel request protocol. It accepts one 2x2 neighbourhood request (integer base coordinate plus Q0.8 fractions) from a bilinear datapath. It reads the source image from a 32-bit-wide, 4-pixels-per-word synchronous RAM over two read ports, extracts the TL/TR/BL/BR pixels, and holds them until the requester consumes them. It sits between the bilinear SIMD lane sequencer and the wide input image memory.

---
 rtl/quad_pixel_fetch.sv | 147 ++++++++++++++
 tb/tb_quad_pixel_fetch.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/quad_pixel_fetch.sv
// Bilinear quad-pixel responder: fetches a 2x2 window from a 4-pixel-per-word RAM
// over two read ports and holds TL/TR/BL/BR until the requester consumes them.
module quad_pixel_fetch #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned IMG_WIDTH  = 16,
    parameter int unsigned IMG_HEIGHT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [15:0]       req_xi_base,
    input  logic [15:0]       req_yi_base,
    input  logic [7:0]        req_fx_q,
    input  logic [7:0]        req_fy_q,
    output logic              req_ready,
    output logic              data_valid,
    output logic [7:0]        pixel_tl,
    output logic [7:0]        pixel_tr,
    output logic [7:0]        pixel_bl,
    output logic [7:0]        pixel_br,
    output logic [7:0]        frac_x,
    output logic [7:0]        frac_y,
    input  logic              data_consumed,
    output logic [ADDR_W-1:0] mem_raddr0,
    input  logic [31:0]       mem_rdata0,
    output logic [ADDR_W-1:0] mem_raddr1,
    input  logic [31:0]       mem_rdata1,
    output logic              err_oob,
    output logic [31:0]       rd_word_count
);

    localparam int unsigned COORD_W = 16;
    localparam int unsigned BYTE_W  = ADDR_W + 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR_A = 3'd1;
    localparam logic [2:0] S_CAP_A  = 3'd2;
    localparam logic [2:0] S_ADDR_B = 3'd3;
    localparam logic [2:0] S_CAP_B  = 3'd4;
    localparam logic [2:0] S_VALID  = 3'd5;

    logic [2:0]         state;
    logic [2:0]         next_state;
    logic [1:0]         lane_top;
    logic [1:0]         lane_bot;
    logic               straddle;
    logic [COORD_W-1:0] xi_c;
    logic [COORD_W-1:0] yi_c;
    logic               oob_c;
    logic [BYTE_W-1:0]  btop_c;
    logic [BYTE_W-1:0]  bbot_c;

    function automatic logic [7:0] lane_pix(input logic [31:0] word, input logic [1:0] lane);
        return word[8*lane +: 8];
    endfunction

    // Clamp the window so it always lies fully inside the image
    always_comb begin
        xi_c  = req_xi_base;
        yi_c  = req_yi_base;
        oob_c = 1'b0;
        if (req_xi_base > COORD_W'(IMG_WIDTH - 2)) begin
            xi_c  = COORD_W'(IMG_WIDTH - 2);
            oob_c = 1'b1;
        end
        if (req_yi_base > COORD_W'(IMG_HEIGHT - 2)) begin
            yi_c  = COORD_W'(IMG_HEIGHT - 2);
            oob_c = 1'b1;
        end
        btop_c = BYTE_W'(32'(yi_c) * 32'(IMG_WIDTH) + 32'(xi_c));
        bbot_c = btop_c + BYTE_W'(IMG_WIDTH);
    end

    assign straddle  = (lane_top == 2'd3) || (lane_bot == 2'd3);
    assign req_ready = (state == S_IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (req_valid) next_state = S_ADDR_A;
            S_ADDR_A: next_state = S_CAP_A;
            S_CAP_A:  next_state = straddle ? S_ADDR_B : S_VALID;
            S_ADDR_B: next_state = S_CAP_B;
            S_CAP_B:  next_state = S_VALID;
            S_VALID:  if (data_consumed) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Address, capture and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_valid    <= 1'b0;
            pixel_tl      <= '0;
            pixel_tr      <= '0;
            pixel_bl      <= '0;
            pixel_br      <= '0;
            frac_x        <= '0;
            frac_y        <= '0;
            mem_raddr0    <= '0;
            mem_raddr1    <= '0;
            lane_top      <= '0;
            lane_bot      <= '0;
            err_oob       <= 1'b0;
            rd_word_count <= '0;
        end else begin
            data_valid <= (next_state == S_VALID);
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        frac_x     <= req_fx_q;
                        frac_y     <= req_fy_q;
                        lane_top   <= btop_c[1:0];
                        lane_bot   <= bbot_c[1:0];
                        mem_raddr0 <= btop_c[BYTE_W-1:2];
                        mem_raddr1 <= bbot_c[BYTE_W-1:2];
                        err_oob    <= err_oob | oob_c;
                    end
                end
                S_CAP_A: begin
                    pixel_tl <= lane_pix(mem_rdata0, lane_top);
                    pixel_bl <= lane_pix(mem_rdata1, lane_bot);
                    if (lane_top != 2'd3) pixel_tr <= lane_pix(mem_rdata0, lane_top + 2'd1);
                    if (lane_bot != 2'd3) pixel_br <= lane_pix(mem_rdata1, lane_bot + 2'd1);
                    if (straddle) begin
                        mem_raddr0 <= mem_raddr0 + ADDR_W'(1);
                        mem_raddr1 <= mem_raddr1 + ADDR_W'(1);
                    end
                    rd_word_count <= rd_word_count + 32'd2;
                end
                S_CAP_B: begin
                    // Only a straddling row takes its right pixel from the next word
                    if (lane_top == 2'd3) pixel_tr <= mem_rdata0[7:0];
                    if (lane_bot == 2'd3) pixel_br <= mem_rdata1[7:0];
                    rd_word_count <= rd_word_count + 32'd2;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_quad_pixel_fetch.sv
// Randomized and directed bench for quad_pixel_fetch against a pixel-level window model.
module tb_quad_pixel_fetch;

    localparam int unsigned ADDR_W = 10;
    localparam int IW = 16;
    localparam int IH = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic [15:0]       req_xi_base;
    logic [15:0]       req_yi_base;
    logic [7:0]        req_fx_q;
    logic [7:0]        req_fy_q;
    logic              req_ready;
    logic              data_valid;
    logic [7:0]        pixel_tl, pixel_tr, pixel_bl, pixel_br;
    logic [7:0]        frac_x, frac_y;
    logic              data_consumed;
    logic [ADDR_W-1:0] mem_raddr0, mem_raddr1;
    logic [31:0]       mem_rdata0, mem_rdata1;
    logic              err_oob;
    logic [31:0]       rd_word_count;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          exp_count;
    logic        exp_err;
    logic        auto_cons;
    logic        cons_man;
    logic        cons_r;

    quad_pixel_fetch dut (
        .clk(clk), .rst(rst), .req_valid(req_valid),
        .req_xi_base(req_xi_base), .req_yi_base(req_yi_base),
        .req_fx_q(req_fx_q), .req_fy_q(req_fy_q), .req_ready(req_ready),
        .data_valid(data_valid), .pixel_tl(pixel_tl), .pixel_tr(pixel_tr),
        .pixel_bl(pixel_bl), .pixel_br(pixel_br), .frac_x(frac_x), .frac_y(frac_y),
        .data_consumed(data_consumed), .mem_raddr0(mem_raddr0), .mem_rdata0(mem_rdata0),
        .mem_raddr1(mem_raddr1), .mem_rdata1(mem_rdata1), .err_oob(err_oob),
        .rd_word_count(rd_word_count)
    );

    always #5 clk = ~clk;

    // Image RAM: pixel at byte address b holds b[7:0]
    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        logic [7:0] b;
        b = 8'({a, 2'b00});
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    always @(posedge clk) begin
        mem_rdata0 <= mem_word(mem_raddr0);
        mem_rdata1 <= mem_word(mem_raddr1);
    end

    // Requester that acknowledges one cycle after seeing data_valid
    always @(posedge clk) cons_r <= data_valid;
    assign data_consumed = auto_cons ? cons_r : cons_man;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_ready", 32'(req_ready), 32'd1);
    endtask

    // One full transaction checked against the window model
    task automatic run_req(input int xi, input int yi, input logic [7:0] fx,
                           input logic [7:0] fy, input int extra_wait);
        int cx, cy, bt, bb, lat;
        logic strad;
        cx = (xi > IW - 2) ? IW - 2 : xi;
        cy = (yi > IH - 2) ? IH - 2 : yi;
        bt = cy * IW + cx;
        bb = bt + IW;
        strad = (bt % 4 == 3) || (bb % 4 == 3);
        wait_ready();
        req_xi_base = 16'(xi);
        req_yi_base = 16'(yi);
        req_fx_q    = fx;
        req_fy_q    = fy;
        req_valid   = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        if (xi != cx || yi != cy) exp_err = 1'b1;
        chk("raddr0_first", 32'(mem_raddr0), 32'(bt / 4));
        chk("raddr1_first", 32'(mem_raddr1), 32'(bb / 4));
        lat = 1;
        while (!data_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), strad ? 32'd5 : 32'd3);
        exp_count += strad ? 4 : 2;
        chk("pixel_tl", 32'(pixel_tl), 32'(bt % 256));
        chk("pixel_tr", 32'(pixel_tr), 32'((bt + 1) % 256));
        chk("pixel_bl", 32'(pixel_bl), 32'(bb % 256));
        chk("pixel_br", 32'(pixel_br), 32'((bb + 1) % 256));
        chk("frac_x", 32'(frac_x), 32'(fx));
        chk("frac_y", 32'(frac_y), 32'(fy));
        chk("err_oob", 32'(err_oob), 32'(exp_err));
        chk("rd_word_count", rd_word_count, 32'(exp_count));
        chk("raddr0_last", 32'(mem_raddr0), 32'(bt / 4 + (strad ? 1 : 0)));
        if (extra_wait > 0) begin
            repeat (extra_wait) @(negedge clk);
            chk("valid_held", 32'(data_valid), 32'd1);
        end
        if (!auto_cons) begin
            cons_man = 1'b1;
            @(negedge clk);
            cons_man = 1'b0;
        end else begin
            lat = 0;
            while (data_valid && lat < 5) begin
                @(negedge clk);
                lat++;
            end
        end
        chk("valid_drop", 32'(data_valid), 32'd0);
        chk("ready_after", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic stable;
        int   n;
        rst = 1'b1; req_valid = 1'b0; req_xi_base = '0; req_yi_base = '0;
        req_fx_q = '0; req_fy_q = '0; cons_man = 1'b0; auto_cons = 1'b0;
        exp_count = 0; exp_err = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_pixels", {pixel_tl, pixel_tr, pixel_bl, pixel_br}, 32'd0);
        chk("rst_frac", 32'({frac_x, frac_y}), 32'd0);
        chk("rst_raddr", 32'({mem_raddr0, mem_raddr1}), 32'd0);
        chk("rst_err", 32'(err_oob), 32'd0);
        chk("rst_count", rd_word_count, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        run_req(5, 2, 8'h11, 8'h22, 0);
        run_req(7, 0, 8'h40, 8'h80, 0);

        // Hold: request kept asserted while output is never consumed
        wait_ready();
        req_xi_base = 16'd5; req_yi_base = 16'd2; req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!data_valid && n < 12) begin
            @(negedge clk);
            n++;
        end
        exp_count += 2;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (pixel_tl != 8'd37 || pixel_tr != 8'd38 || pixel_bl != 8'd53 ||
                pixel_br != 8'd54 || mem_raddr0 != 10'd9 || !data_valid || req_ready)
                stable = 1'b0;
        end
        chk("hold_stable", 32'(stable), 32'd1);
        chk("hold_count", rd_word_count, 32'(exp_count));
        req_valid = 1'b0; cons_man = 1'b1;
        @(negedge clk);
        cons_man = 1'b0;
        chk("hold_release_ready", 32'(req_ready), 32'd1);
        chk("hold_release_valid", 32'(data_valid), 32'd0);

        run_req(15, 20, 8'h01, 8'hff, 0);
        run_req(2, 3, 8'h00, 8'h00, 0);

        // Reset while the second straddle word is being addressed
        wait_ready();
        req_xi_base = 16'd3; req_yi_base = 16'd1; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(data_valid), 32'd0);
        chk("midrst_raddr", 32'({mem_raddr0, mem_raddr1}), 32'd0);
        chk("midrst_count", rd_word_count, 32'd0);
        chk("midrst_err", 32'(err_oob), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_count = 0; exp_err = 1'b0;
        run_req(5, 2, 8'h33, 8'h44, 0);

        // Four-lane sequence with late, registered acknowledges
        auto_cons = 1'b1;
        for (int i = 0; i < 4; i++) run_req(3 * i, 4, 8'(i), 8'(16 * i), 0);
        auto_cons = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            auto_cons = 1'($urandom_range(0, 1));
            run_req(int'($urandom_range(0, 19)), int'($urandom_range(0, 19)),
                    8'($urandom), 8'($urandom), auto_cons ? 0 : int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
